// File: rtl/img_mem_pkg.sv
// Shared definitions for the image-memory sequencer: opcodes, FSM states and a
// constant-foldable clog2 used to size counters.
package img_mem_pkg;

  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_WR   = 3'b010;
  localparam logic [2:0] OP_COPY = 3'b011;
  localparam logic [2:0] OP_ZIN  = 3'b100;
  localparam logic [2:0] OP_ZOUT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_PH = 2'd1,
    ST_WR_PH = 2'd2,
    ST_NEXT  = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Raster x/y counters over the destination frame plus per-pixel source and
// destination address arithmetic for COPY, ZOOM_IN and ZOOM_OUT passes.
module img_addr_gen
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned IMG_W  = 160,
  parameter int unsigned IMG_H  = 120
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [2:0]        op,
  input  logic [2:0]        zoom,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] src_addr_c,
  output logic [ADDR_W-1:0] dst_addr_c,
  output logic              last_pixel_c
);

  localparam int unsigned CW = clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(IMG_W);

  logic [CW-1:0]     x_q, x_d, y_q, y_d;
  logic [CW-1:0]     w_dst, h_dst;
  logic [ADDR_W-1:0] sx, sy, src_off;

  // Destination frame shrinks only for decimation.
  always_comb begin
    w_dst = CW'(IMG_W);
    h_dst = CW'(IMG_H);
    if (op == OP_ZOUT) begin
      w_dst = CW'(IMG_W) >> zoom;
      h_dst = CW'(IMG_H) >> zoom;
    end
    last_pixel_c = (x_q == w_dst - CW'(1)) && (y_q == h_dst - CW'(1));
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_q == w_dst - CW'(1)) begin
        x_d = '0;
        y_d = y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Addresses follow the next counter values so a registered addr_out lines up
  // with the pixel being entered.
  always_comb begin
    sx = ADDR_W'(x_d);
    sy = ADDR_W'(y_d);
    case (op)
      OP_ZIN:  src_off = ((sy >> zoom) * ROW) + (sx >> zoom);
      OP_ZOUT: src_off = ((sy << zoom) * ROW) + (sx << zoom);
      default: src_off = (sy * ROW) + sx;
    endcase
    src_addr_c = src_base + src_off;
    dst_addr_c = dst_base + (sy * ADDR_W'(w_dst)) + sx;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/img_mem_sequencer.sv
// Sequences single reads/writes and whole-frame copy/zoom passes onto a
// single-port frame memory; every pixel is a fixed-length read then write phase.
module img_mem_sequencer
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 120,
  parameter int unsigned MEM_LAT  = 3,
  parameter int unsigned ZOOM_MAX = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [2:0]                            operation,
  input  logic [2:0]                            current_zoom,
  input  logic                                  abort,
  input  logic [ADDR_W-1:0]                     addr_base,
  input  logic [ADDR_W-1:0]                     dst_base,
  input  logic [DATA_W-1:0]                     wr_data_in,
  input  logic [DATA_W-1:0]                     rd_data_in,
  output logic [ADDR_W-1:0]                     addr_out,
  output logic                                  wr_enable,
  output logic [DATA_W-1:0]                     wr_data_out,
  output logic [DATA_W-1:0]                     rd_data_out,
  output logic                                  done,
  output logic                                  busy,
  output logic                                  error,
  output logic [clog2(IMG_W*IMG_H+1)-1:0]       step_count
);

  localparam int unsigned SW      = clog2(IMG_W * IMG_H + 1);
  localparam int unsigned PW      = (clog2(MEM_LAT) > 0) ? clog2(MEM_LAT) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        zoom_q, zoom_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [SW-1:0]     step_q, step_d;

  logic              gen_clr, gen_adv;
  logic [ADDR_W-1:0] gen_src_c, gen_dst_c;
  logic              gen_last_c;
  logic              is_zoom_c, illegal_c;

  img_addr_gen #(
    .ADDR_W (ADDR_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_addr_gen (
    .clock        (clock),
    .reset_n      (reset_n),
    .clr          (gen_clr),
    .adv          (gen_adv),
    .op           (op_q),
    .zoom         (zoom_q),
    .src_base     (src_base_q),
    .dst_base     (dst_base_q),
    .src_addr_c   (gen_src_c),
    .dst_addr_c   (gen_dst_c),
    .last_pixel_c (gen_last_c)
  );

  // Start-request legality, evaluated on the live inputs.
  always_comb begin
    is_zoom_c = (operation == OP_ZIN) || (operation == OP_ZOUT);
    illegal_c = (operation == 3'b000) || (operation > OP_ZOUT) ||
                (is_zoom_c && (current_zoom > 3'(ZOOM_MAX)));
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    op_d       = op_q;
    zoom_d     = zoom_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    step_d     = step_q;
    err_d      = 1'b0;
    gen_clr    = 1'b0;
    gen_adv    = 1'b0;

    // Abort wins over any phase completion in flight.
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
      ph_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            op_d       = operation;
            zoom_d     = current_zoom;
            src_base_d = addr_base;
            dst_base_d = dst_base;
            step_d     = '0;
            gen_clr    = 1'b1;
            if (illegal_c) begin
              err_d = 1'b1;
            end else begin
              ph_d   = '0;
              addr_d = addr_base;
              if (operation == OP_WR) begin
                state_d   = ST_WR_PH;
                wr_data_d = wr_data_in;
              end else begin
                state_d = ST_RD_PH;
              end
            end
          end
        end
        ST_RD_PH: begin
          if (ph_q == LAST_PH) begin
            ph_d      = '0;
            rd_data_d = rd_data_in;
            if (op_q == OP_RD) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_WR_PH;
              addr_d    = gen_dst_c;
              wr_data_d = rd_data_in;
            end
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
        ST_WR_PH: begin
          if (ph_q == LAST_PH) begin
            ph_d    = '0;
            state_d = (op_q == OP_WR) ? ST_IDLE : ST_NEXT;
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end
        ST_NEXT: begin
          step_d = step_q + SW'(1);
          if (gen_last_c) begin
            state_d = ST_IDLE;
          end else begin
            gen_adv = 1'b1;
            state_d = ST_RD_PH;
            addr_d  = gen_src_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wr_en_d = (state_d == ST_WR_PH);
    done_d  = (state_d == ST_IDLE);
    busy_d  = ~done_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      op_q       <= '0;
      zoom_q     <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      op_q       <= op_d;
      zoom_q     <= zoom_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      step_q     <= step_d;
    end
  end

  assign addr_out    = addr_q;
  assign wr_enable   = wr_en_q;
  assign wr_data_out = wr_data_q;
  assign rd_data_out = rd_data_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign error       = err_q;
  assign step_count  = step_q;

endmodule

// File: tb/tb_img_mem_sequencer.sv
// Directed bench for img_mem_sequencer on a 4x4 frame with MEM_LAT=3 and a
// behavioural frame memory preloaded with 0x10+addr at locations 0..15.
module tb_img_mem_sequencer;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [2:0]    operation;
  logic [2:0]    current_zoom;
  logic          abort;
  logic [AW-1:0] addr_base;
  logic [AW-1:0] dst_base;
  logic [DW-1:0] wr_data_in;
  logic [DW-1:0] rd_data_in;
  logic [AW-1:0] addr_out;
  logic          wr_enable;
  logic [DW-1:0] wr_data_out;
  logic [DW-1:0] rd_data_out;
  logic          done;
  logic          busy;
  logic          error;
  logic [SW-1:0] step_count;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  img_mem_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .IMG_W(4), .IMG_H(4), .MEM_LAT(3), .ZOOM_MAX(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .operation    (operation),
    .current_zoom (current_zoom),
    .abort        (abort),
    .addr_base    (addr_base),
    .dst_base     (dst_base),
    .wr_data_in   (wr_data_in),
    .rd_data_in   (rd_data_in),
    .addr_out     (addr_out),
    .wr_enable    (wr_enable),
    .wr_data_out  (wr_data_out),
    .rd_data_out  (rd_data_out),
    .done         (done),
    .busy         (busy),
    .error        (error),
    .step_count   (step_count)
  );

  logic [7:0] mem [0:8191];
  assign rd_data_in = mem[addr_out[12:0]];

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
    end else if (wr_enable) begin
      mem[addr_out[12:0]] <= wr_data_out;
    end
  end

  // Activity log: read phase starts, write phase starts, write strobe cycles.
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wa_log[$];
  logic [7:0]    wd_log[$];
  int            wr_cycles = 0;
  logic          prev_busy = 1'b0;
  logic          prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clock) begin
    if (busy === 1'b1 && wr_enable === 1'b0 && (!prev_busy || addr_out != prev_addr))
      rd_log.push_back(addr_out);
    if (wr_enable === 1'b1 && !prev_wr) begin
      wa_log.push_back(addr_out);
      wd_log.push_back(wr_data_out);
    end
    if (wr_enable === 1'b1) wr_cycles++;
    prev_busy = (busy === 1'b1);
    prev_wr   = (wr_enable === 1'b1);
    prev_addr = addr_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [2:0] z,
                          input logic [AW-1:0] a, input logic [AW-1:0] d,
                          input logic [7:0] w);
    @(negedge clock);
    operation = op; current_zoom = z; addr_base = a; dst_base = d;
    wr_data_in = w; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clock);
    end
    if (cyc >= 2000) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_pass(input string nm, input int r0, input int w0,
                            input int exp_src[$], input logic [AW-1:0] dbase);
    chk($sformatf("%s_nrd", nm), 32'(rd_log.size() - r0), 32'(exp_src.size()));
    chk($sformatf("%s_nwr", nm), 32'(wa_log.size() - w0), 32'(exp_src.size()));
    for (int i = 0; i < exp_src.size(); i++) begin
      if (r0 + i < rd_log.size())
        chk($sformatf("%s_src%0d", nm, i), 32'(rd_log[r0+i]), 32'(exp_src[i]));
      if (w0 + i < wa_log.size()) begin
        chk($sformatf("%s_dst%0d", nm, i), 32'(wa_log[w0+i]), 32'(dbase) + 32'(i));
        chk($sformatf("%s_dat%0d", nm, i), 32'(wd_log[w0+i]), 32'(8'h10 + exp_src[i]));
      end
    end
  endtask

  initial begin
    int cyc, r0, w0, wc0;
    int src_copy[$];
    int src_zin[$];
    int src_zout[$];

    reset_n = 1'b0; enable = 1'b0; operation = '0; current_zoom = '0; abort = 1'b0;
    addr_base = '0; dst_base = '0; wr_data_in = '0;
    repeat (3) @(negedge clock);

    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_wren", 32'(wr_enable), 32'h0);
    chk("rst_wdat", 32'(wr_data_out), 32'h0);
    chk("rst_rdat", 32'(rd_data_out), 32'h0);
    chk("rst_done", 32'(done), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(error), 32'h0);
    chk("rst_step", 32'(step_count), 32'h0);
    reset_n = 1'b1;

    // Single write then read-back.
    w0 = wa_log.size(); wc0 = wr_cycles;
    start_op(3'b010, 3'd0, 17'h01000, 17'h0, 8'hAB);
    chk("wr_addr", 32'(addr_out), 32'h01000);
    wait_idle(cyc);
    chk("wr_busy_cyc", 32'(cyc), 32'd3);
    chk("wr_strobe_cyc", 32'(wr_cycles - wc0), 32'd3);
    chk("wr_log_addr", (wa_log.size() > w0) ? 32'(wa_log[w0]) : 32'hDEAD, 32'h01000);
    chk("wr_mem", 32'(mem[13'h1000]), 32'hAB);

    r0 = rd_log.size(); wc0 = wr_cycles;
    start_op(3'b001, 3'd0, 17'h01000, 17'h0, 8'h00);
    wait_idle(cyc);
    chk("rd_busy_cyc", 32'(cyc), 32'd3);
    chk("rd_data", 32'(rd_data_out), 32'hAB);
    chk("rd_no_wr", 32'(wr_cycles - wc0), 32'd0);
    chk("rd_log_addr", (rd_log.size() > r0) ? 32'(rd_log[r0]) : 32'hDEAD, 32'h01000);
    chk("rd_done", 32'(done), 32'h1);

    // COPY 4x4 into 0x100.
    for (int i = 0; i < 16; i++) src_copy.push_back(i);
    r0 = rd_log.size(); w0 = wa_log.size();
    start_op(3'b011, 3'd0, 17'h0, 17'h100, 8'h00);
    wait_idle(cyc);
    chk("copy_busy_cyc", 32'(cyc), 32'd112);
    chk("copy_step", 32'(step_count), 32'd16);
    check_pass("copy", r0, w0, src_copy, 17'h100);

    // ZOOM_IN z=1 into 0x200: each 2x2 block replicates one source pixel.
    src_zin = '{0, 0, 1, 1, 0, 0, 1, 1, 4, 4, 5, 5, 4, 4, 5, 5};
    r0 = rd_log.size(); w0 = wa_log.size();
    start_op(3'b100, 3'd1, 17'h0, 17'h200, 8'h00);
    wait_idle(cyc);
    chk("zin_busy_cyc", 32'(cyc), 32'd112);
    chk("zin_step", 32'(step_count), 32'd16);
    check_pass("zin", r0, w0, src_zin, 17'h200);

    // ZOOM_OUT z=1 into 0x300: 2x2 destination.
    src_zout = '{0, 2, 8, 10};
    r0 = rd_log.size(); w0 = wa_log.size();
    start_op(3'b101, 3'd1, 17'h0, 17'h300, 8'h00);
    wait_idle(cyc);
    chk("zout_busy_cyc", 32'(cyc), 32'd28);
    chk("zout_step", 32'(step_count), 32'd4);
    check_pass("zout", r0, w0, src_zout, 17'h300);

    // Rejected starts: illegal opcode, zoom beyond limit.
    r0 = rd_log.size(); wc0 = wr_cycles;
    start_op(3'b111, 3'd0, 17'h0, 17'h0, 8'h00);
    chk("err_op_pulse", 32'(error), 32'h1);
    chk("err_op_done", 32'(done), 32'h1);
    @(negedge clock);
    chk("err_op_clear", 32'(error), 32'h0);
    start_op(3'b100, 3'd3, 17'h0, 17'h0, 8'h00);
    chk("err_zin_pulse", 32'(error), 32'h1);
    chk("err_zin_busy", 32'(busy), 32'h0);
    @(negedge clock);
    chk("err_zin_clear", 32'(error), 32'h0);
    chk("err_zin_done", 32'(done), 32'h1);
    chk("err_no_rd", 32'(rd_log.size() - r0), 32'd0);
    chk("err_no_wr", 32'(wr_cycles - wc0), 32'd0);

    // Abort in the 2nd WR_PH cycle of pixel 5.
    start_op(3'b011, 3'd0, 17'h0, 17'h400, 8'h00);
    cyc = 0;
    while (!(step_count == 5 && wr_enable === 1'b1) && cyc < 500) begin
      cyc++;
      @(negedge clock);
    end
    if (cyc >= 500) chk("abort_wait_timeout", 32'd1, 32'd0);
    @(negedge clock);
    chk("abort_pre_wren", 32'(wr_enable), 32'h1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_wren", 32'(wr_enable), 32'h0);
    chk("abort_done", 32'(done), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_step", 32'(step_count), 32'd5);

    // Reset mid-pass.
    start_op(3'b011, 3'd0, 17'h0, 17'h100, 8'h00);
    repeat (20) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mrst_addr", 32'(addr_out), 32'h0);
    chk("mrst_wren", 32'(wr_enable), 32'h0);
    chk("mrst_wdat", 32'(wr_data_out), 32'h0);
    chk("mrst_rdat", 32'(rd_data_out), 32'h0);
    chk("mrst_done", 32'(done), 32'h1);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_step", 32'(step_count), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
